// File: rtl/tick_div_pkg.sv
// tick_div_pkg: shared widths, reset divisors, FSM states and divisor helper for the tick cascade.
package tick_div_pkg;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_NUM_STAGES = 3;
   localparam logic [DEF_NUM_STAGES*DEF_CNT_W-1:0] DEF_DIV_VEC = {8'd10, 8'd10, 8'd100};
   typedef enum logic {ST_RUN, ST_DONE} state_e;
   // A divisor of zero behaves like one so a stage can never stall.
   function automatic logic [31:0] div_eff(input logic [31:0] d);
      return (d == 32'd0) ? 32'd1 : d;
   endfunction
endpackage

// File: rtl/tick_cascade_divider_if.sv
// tick_cascade_divider_if: strobe, control and readback bundle of the tick cascade divider.
interface tick_cascade_divider_if import tick_div_pkg::*; #(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int CNT_W = DEF_CNT_W
);
   logic tick_in;
   logic enable;
   logic clear;
   logic load;
   logic one_shot;
   logic [NUM_STAGES*CNT_W-1:0] div_in;
   logic [NUM_STAGES-1:0] tick_out;
   logic [NUM_STAGES*CNT_W-1:0] count_out;
   logic done;
   modport master(output tick_in, enable, clear, load, one_shot, div_in, input tick_out, count_out, done);
   modport slave(input tick_in, enable, clear, load, one_shot, div_in, output tick_out, count_out, done);
endinterface

// File: rtl/tick_div_stage.sv
// tick_div_stage: one divide-by-N counter with terminal compare and a registered output strobe.
module tick_div_stage import tick_div_pkg::*; #(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             strobe_i,
   input  logic [CNT_W-1:0] div_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tick_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d, div_e;
   logic tick_q, tick_d, term;
   always_comb begin
      div_e = CNT_W'(div_eff(32'(div_i)));
      term = cnt_q == div_e - CNT_W'(1);
      tick_d = strobe_i & term & ~flush;
      cnt_d = flush ? '0 : strobe_i ? (term ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tick_q <= tick_d;
      end
   end
   assign cnt_o = cnt_q;
   assign tick_o = tick_q;
endmodule

// File: rtl/tick_cascade_divider.sv
// tick_cascade_divider: chain of runtime-loadable divide-by-N stages turning an input strobe into slower strobes.
module tick_cascade_divider import tick_div_pkg::*; #(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int CNT_W = DEF_CNT_W,
   parameter logic [NUM_STAGES*CNT_W-1:0] DEF_DIV = DEF_DIV_VEC
) (
   input logic clk,
   input logic reset,
   tick_cascade_divider_if.slave bus
);
   localparam int L = (NUM_STAGES-1)*CNT_W;
   logic [NUM_STAGES*CNT_W-1:0] div_q;
   logic [NUM_STAGES-1:0] strobe, tick;
   logic flush, fire_last;
   state_e state_q;
   assign flush = bus.load | bus.clear;
   // Last stage reaches terminal this cycle, so done rises together with its strobe.
   assign fire_last = strobe[NUM_STAGES-1] &
      (bus.count_out[L +: CNT_W] == CNT_W'(div_eff(32'(div_q[L +: CNT_W])) - 32'd1));
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= DEF_DIV;
         state_q <= ST_RUN;
      end else begin
         div_q <= bus.load ? bus.div_in : div_q;
         if (flush) state_q <= ST_RUN;
         else if (state_q == ST_RUN && bus.one_shot && fire_last) state_q <= ST_DONE;
      end
   end
   for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      if (i == 0) begin : g_first
         assign strobe[i] = bus.tick_in & bus.enable & (state_q != ST_DONE);
      end else begin : g_next
         assign strobe[i] = tick[i-1];
      end
      tick_div_stage #(.CNT_W(CNT_W)) u_stage (
         .clk(clk),
         .reset(reset),
         .flush(flush),
         .strobe_i(strobe[i]),
         .div_i(div_q[i*CNT_W +: CNT_W]),
         .cnt_o(bus.count_out[i*CNT_W +: CNT_W]),
         .tick_o(tick[i])
      );
   end
   assign bus.tick_out = tick;
   assign bus.done = state_q == ST_DONE;
endmodule

// File: tb/tb_tick_cascade_divider.sv
// tb_tick_cascade_divider: vector table plus corner sequences, with a per-stage strobe timing scoreboard.
module tb_tick_cascade_divider;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   tick_cascade_divider_if #(.NUM_STAGES(3), .CNT_W(8)) bus();
   tick_cascade_divider #(.NUM_STAGES(3), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      bit use_def;
      int d0, d1, d2;
      int n, gap;
      bit os;
      int e0, e1, e2;
      bit edone;
   } vec_t;
   vec_t vt[6];

   int chk = 0, err = 0, cyc = 0;
   int obs[3];
   int md[3], mc[3];
   bit mdone;
   int done_edge;
   int q0[$], q1[$], q2[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string nm, int act, int exp);
      chk++;
      if (act != exp) begin
         err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic int eff(int d);
      return (d == 0) ? 1 : d;
   endfunction

   function automatic int qsize(int i);
      return (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
   endfunction

   function automatic int qfront(int i);
      return (i == 0) ? q0[0] : (i == 1) ? q1[0] : q2[0];
   endfunction

   function automatic int qpop(int i);
      if (i == 0) return q0.pop_front();
      if (i == 1) return q1.pop_front();
      return q2.pop_front();
   endfunction

   function automatic void qpush(int i, int c);
      if (i == 0) q0.push_back(c);
      else if (i == 1) q1.push_back(c);
      else q2.push_back(c);
   endfunction

   function automatic void purge(int f);
      while (q0.size() > 0 && q0[$] >= f) void'(q0.pop_back());
      while (q1.size() > 0 && q1[$] >= f) void'(q1.pop_back());
      while (q2.size() > 0 && q2[$] >= f) void'(q2.pop_back());
   endfunction

   function automatic void model_flush(int f);
      for (int i = 0; i < 3; i++) mc[i] = 0;
      mdone = 0;
      purge(f);
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         while (qsize(i) > 0 && qfront(i) < cyc) check($sformatf("stage%0d_missing", i), cyc, qpop(i));
         if (bus.tick_out[i]) begin
            obs[i]++;
            if (qsize(i) == 0) check($sformatf("stage%0d_unexpected", i), cyc, -1);
            else check($sformatf("stage%0d_time", i), cyc, qpop(i));
         end
      end
   end

   task automatic drive_strobe(int gap);
      int s;
      bit carry;
      bus.tick_in = 1'b1;
      s = cyc + 1;
      if (bus.enable && (!mdone || s <= done_edge)) begin
         carry = 1;
         for (int i = 0; i < 3; i++) begin
            if (carry) begin
               if (mc[i] == eff(md[i]) - 1) begin
                  mc[i] = 0;
                  qpush(i, s + i);
                  if (i == 2 && bus.one_shot && !mdone) begin
                     mdone = 1;
                     done_edge = s + 2;
                  end
               end else begin
                  mc[i]++;
                  carry = 0;
               end
            end
         end
      end
      @(negedge clk);
      bus.tick_in = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic do_load(int d0, int d1, int d2);
      bus.load = 1'b1;
      bus.div_in = {8'(d2), 8'(d1), 8'(d0)};
      md[0] = d0; md[1] = d1; md[2] = d2;
      model_flush(cyc + 1);
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic do_clear(bit with_tick);
      bus.clear = 1'b1;
      bus.tick_in = with_tick;
      model_flush(cyc + 1);
      @(negedge clk);
      bus.clear = 1'b0;
      bus.tick_in = 1'b0;
   endtask

   task automatic model_reset();
      md[0] = 100; md[1] = 10; md[2] = 10;
      model_flush(0);
   endtask

   task automatic check_counts(string nm);
      for (int i = 0; i < 3; i++) check($sformatf("%s_count%0d", nm, i), int'(bus.count_out[i*8 +: 8]), mc[i]);
   endtask

   task automatic clear_obs();
      for (int i = 0; i < 3; i++) obs[i] = 0;
   endtask

   initial begin
      vt[0] = '{1, 100, 10, 10, 10000, 3, 0, 100, 10, 1, 0};
      vt[1] = '{0, 4, 3, 2, 24, 3, 0, 6, 2, 1, 0};
      vt[2] = '{0, 1, 0, 5, 5, 3, 0, 5, 5, 1, 0};
      vt[3] = '{0, 3, 2, 2, 12, 1, 0, 4, 2, 1, 0};
      vt[4] = '{0, 255, 2, 2, 255, 1, 0, 1, 0, 0, 0};
      vt[5] = '{0, 2, 2, 2, 20, 3, 1, 4, 2, 1, 1};
      bus.tick_in = 0; bus.enable = 1; bus.clear = 0; bus.load = 0; bus.one_shot = 0; bus.div_in = '0;
      reset = 1'b1;
      model_reset();
      clear_obs();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_tick_out", int'(bus.tick_out), 0);
      check("reset_count_out", int'(bus.count_out), 0);
      check("reset_done", int'(bus.done), 0);

      for (int v = 0; v < 6; v++) begin
         clear_obs();
         if (!vt[v].use_def) do_load(vt[v].d0, vt[v].d1, vt[v].d2);
         bus.one_shot = vt[v].os;
         for (int k = 0; k < vt[v].n; k++) drive_strobe(vt[v].gap);
         repeat (8) @(negedge clk);
         check($sformatf("v%0d_pulses0", v), obs[0], vt[v].e0);
         check($sformatf("v%0d_pulses1", v), obs[1], vt[v].e1);
         check($sformatf("v%0d_pulses2", v), obs[2], vt[v].e2);
         check($sformatf("v%0d_done", v), int'(bus.done), int'(vt[v].edone));
         check($sformatf("v%0d_pending", v), qsize(0) + qsize(1) + qsize(2), 0);
         check_counts($sformatf("v%0d", v));
      end

      // one-shot release by clear
      do_clear(0);
      check("clear_releases_done", int'(bus.done), 0);
      bus.one_shot = 0;
      clear_obs();
      drive_strobe(3);
      drive_strobe(3);
      repeat (4) @(negedge clk);
      check("resume_pulses0", obs[0], 1);

      // load mid-count restarts counts
      do_load(4, 3, 2);
      for (int k = 0; k < 5; k++) drive_strobe(3);
      check("midload_pre_count0", int'(bus.count_out[7:0]), 1);
      check("midload_pre_count1", int'(bus.count_out[15:8]), 1);
      do_load(4, 3, 2);
      check("midload_count_zero", int'(bus.count_out), 0);
      clear_obs();
      for (int k = 0; k < 24; k++) drive_strobe(3);
      repeat (6) @(negedge clk);
      check("midload_pulses0", obs[0], 6);
      check("midload_pulses1", obs[1], 2);
      check("midload_pulses2", obs[2], 1);

      // enable masked during raw strobes 50..59
      do_load(100, 10, 10);
      clear_obs();
      for (int r = 1; r <= 109; r++) begin
         bus.enable = !(r >= 50 && r <= 59);
         drive_strobe(3);
      end
      repeat (4) @(negedge clk);
      check("enable_gap_before110", obs[0], 0);
      drive_strobe(3);
      repeat (4) @(negedge clk);
      check("enable_gap_at110", obs[0], 1);
      for (int k = 0; k < 3; k++) drive_strobe(3);
      check("preclear_count0", int'(bus.count_out[7:0]), 3);
      do_clear(1);
      check("clear_with_tick_count", int'(bus.count_out), 0);
      repeat (3) @(negedge clk);
      check("clear_with_tick_pulses", obs[0], 1);

      // reset mid-run restores default divisors
      do_load(200, 10, 10);
      for (int k = 0; k < 57; k++) drive_strobe(3);
      check("prereset_count0", int'(bus.count_out[7:0]), 57);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      check("midreset_count_out", int'(bus.count_out), 0);
      check("midreset_tick_out", int'(bus.tick_out), 0);
      check("midreset_done", int'(bus.done), 0);
      clear_obs();
      for (int k = 0; k < 100; k++) drive_strobe(3);
      repeat (4) @(negedge clk);
      check("default_div_restored", obs[0], 1);
      check_counts("final");

      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end
endmodule
